// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage and its IF/ID register.
package fetch_pkg;

    localparam int unsigned DEF_WIDTH   = 16;
    localparam int unsigned DEF_PCWIDTH = 16;
    localparam int unsigned OPCODE_BITS = 4;

    localparam logic [DEF_WIDTH-1:0]   NOP             = '0;
    localparam logic [OPCODE_BITS-1:0] HALT_OPCODE_DEF = 4'hF;

    typedef enum logic {
        FETCH,
        HALTED
    } fetch_state_t;

    function automatic logic is_halt(input logic [OPCODE_BITS-1:0] opcode,
                                     input logic [OPCODE_BITS-1:0] halt_opcode);
        return opcode == halt_opcode;
    endfunction

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: flush beats stall, stall beats load, anything else is a bubble.
module if_id_register
    import fetch_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned PCWIDTH = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               stall_i,
    input  logic               load_i,
    input  logic [WIDTH-1:0]   instruction_i,
    input  logic [PCWIDTH-1:0] pc_plus1_i,
    output logic [WIDTH-1:0]   instruction_o,
    output logic [PCWIDTH-1:0] pc_plus1_o,
    output logic               valid_o
);

    logic [WIDTH-1:0]   instruction_q, instruction_d;
    logic [PCWIDTH-1:0] pc_plus1_q, pc_plus1_d;
    logic               valid_q, valid_d;

    always_comb begin
        instruction_d = WIDTH'(NOP);
        pc_plus1_d    = '0;
        valid_d       = 1'b0;
        if (flush_i) begin
            instruction_d = WIDTH'(NOP);
            pc_plus1_d    = '0;
            valid_d       = 1'b0;
        end else if (stall_i) begin
            instruction_d = instruction_q;
            pc_plus1_d    = pc_plus1_q;
            valid_d       = valid_q;
        end else if (load_i) begin
            instruction_d = instruction_i;
            pc_plus1_d    = pc_plus1_i;
            valid_d       = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instruction_q <= WIDTH'(NOP);
            pc_plus1_q    <= '0;
            valid_q       <= 1'b0;
        end else begin
            instruction_q <= instruction_d;
            pc_plus1_q    <= pc_plus1_d;
            valid_q       <= valid_d;
        end
    end

    assign instruction_o = instruction_q;
    assign pc_plus1_o    = pc_plus1_q;
    assign valid_o       = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, talks to a variable-latency instruction memory and feeds
// the IF/ID register. Branches that land mid-request are parked until the memory completes.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned         WIDTH       = 16,
    parameter int unsigned         PCWIDTH     = 16,
    parameter logic [PCWIDTH-1:0]  RESET_PC    = '0,
    parameter logic [3:0]          HALT_OPCODE = HALT_OPCODE_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallF,
    input  logic               stallD,
    input  logic               flushD,
    input  logic               takeBranchE,
    input  logic [PCWIDTH-1:0] branchTargetE,
    output logic               imemRequest,
    output logic [PCWIDTH-1:0] imemAddress,
    input  logic [WIDTH-1:0]   imemReadData,
    input  logic               imemReady,
    output logic [WIDTH-1:0]   instructionD,
    output logic [PCWIDTH-1:0] pcPlus1D,
    output logic               validD,
    output logic               haltedF
);

    fetch_state_t       state_q, state_d;
    logic [PCWIDTH-1:0] pc_q, pc_d;
    logic [PCWIDTH-1:0] pending_target_q, pending_target_d;
    logic               redirect_pending_q, redirect_pending_d;

    logic [PCWIDTH-1:0] pc_plus1;
    logic               mem_done;
    logic               fetch_ok;

    assign pc_plus1    = pc_q + PCWIDTH'(1);
    assign imemRequest = (state_q == FETCH);
    assign imemAddress = pc_q;
    assign haltedF     = (state_q == HALTED);

    // Ready only means something while a request is actually outstanding.
    assign mem_done = imemReady && imemRequest;
    assign fetch_ok = mem_done && !redirect_pending_q && !takeBranchE && !stallF;

    always_comb begin
        state_d            = state_q;
        pc_d               = pc_q;
        pending_target_d   = pending_target_q;
        redirect_pending_d = redirect_pending_q;

        if (takeBranchE && (mem_done || state_q == HALTED)) begin
            pc_d               = branchTargetE;
            state_d            = FETCH;
            redirect_pending_d = 1'b0;
        end else if (takeBranchE) begin
            // Request still in flight: address must stay put, so remember where to go.
            pending_target_d   = branchTargetE;
            redirect_pending_d = 1'b1;
        end else if (stallF) begin
            pc_d = pc_q;
        end else if (mem_done && redirect_pending_q) begin
            pc_d               = pending_target_q;
            redirect_pending_d = 1'b0;
        end else if (fetch_ok) begin
            pc_d = pc_plus1;
            if (is_halt(imemReadData[WIDTH-1 -: 4], HALT_OPCODE)) begin
                state_d = HALTED;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= FETCH;
            pc_q               <= RESET_PC;
            pending_target_q   <= '0;
            redirect_pending_q <= 1'b0;
        end else begin
            state_q            <= state_d;
            pc_q               <= pc_d;
            pending_target_q   <= pending_target_d;
            redirect_pending_q <= redirect_pending_d;
        end
    end

    if_id_register #(
        .WIDTH   (WIDTH),
        .PCWIDTH (PCWIDTH)
    ) u_if_id (
        .clk_i         (clk),
        .rst_i         (rst),
        .flush_i       (flushD),
        .stall_i       (stallD),
        .load_i        (fetch_ok),
        .instruction_i (imemReadData),
        .pc_plus1_i    (pc_plus1),
        .instruction_o (instructionD),
        .pc_plus1_o    (pcPlus1D),
        .valid_o       (validD)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Randomised bench for fetch_stage: a reference model predicts PC/halt state and the stream of
// instructions entering decode; a separate monitor compares the DUT against it.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stallF = 1'b0, stallD = 1'b0, flushD = 1'b0, takeBranchE = 1'b0;
    logic [15:0] branchTargetE = '0;
    logic        imemRequest;
    logic [15:0] imemAddress;
    logic [15:0] imemReadData = '0;
    logic        imemReady = 1'b0;
    logic [15:0] instructionD, pcPlus1D;
    logic        validD, haltedF;

    always #5 clk = ~clk;

    fetch_stage #(
        .WIDTH       (16),
        .PCWIDTH     (16),
        .RESET_PC    (16'h0000),
        .HALT_OPCODE (4'hF)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stallF        (stallF),
        .stallD        (stallD),
        .flushD        (flushD),
        .takeBranchE   (takeBranchE),
        .branchTargetE (branchTargetE),
        .imemRequest   (imemRequest),
        .imemAddress   (imemAddress),
        .imemReadData  (imemReadData),
        .imemReady     (imemReady),
        .instructionD  (instructionD),
        .pcPlus1D      (pcPlus1D),
        .validD        (validD),
        .haltedF       (haltedF)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc1;
    } d_entry_t;
    d_entry_t exp_q[$];

    // Reference model state
    logic [15:0] m_pc = '0, m_tgt = '0;
    bit          m_halt = 0, m_redir = 0, m_dv = 0;

    // Memory environment
    bit          outst = 0;
    logic [15:0] o_addr = '0;
    int          wcnt = 0, lat = 0;
    int          lat_mode = 0;
    int          halt_addr = -1;
    bit          rand_halt = 0;
    bit          mon_en = 0;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (halt_addr >= 0 && a == halt_addr[15:0]) return 16'hF123;
        if (rand_halt && a[7:0] == 8'h33) return {4'hF, a[11:0]};
        return a + 16'h1000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit r, input bit sf, input bit sd, input bit fl, input bit br,
                         input logic [15:0] tgt);
        logic [15:0] word, n_pc, n_tgt;
        bit          ok, n_halt, n_redir, n_dv;
        d_entry_t    e;
        @(negedge clk);
        rst = r; stallF = sf; stallD = sd; flushD = fl; takeBranchE = br; branchTargetE = tgt;
        if (imemRequest !== 1'b1) begin
            outst     = 0;
            imemReady = 1'b0;
        end else begin
            if (!outst || imemAddress != o_addr) begin
                outst  = 1;
                o_addr = imemAddress;
                wcnt   = 0;
                lat    = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
            end
            imemReady = (wcnt >= lat);
        end
        imemReadData = mem_word(imemAddress);

        // Model: what should happen at the coming edge
        word = mem_word(m_pc);
        n_pc = m_pc; n_tgt = m_tgt; n_halt = m_halt; n_redir = m_redir; n_dv = 0;
        ok = !r && imemReady && !m_redir && !br && !sf;
        if (r) begin
            n_pc = 16'h0000; n_halt = 0; n_redir = 0; n_tgt = '0;
        end else if (br && (imemReady || m_halt)) begin
            n_pc = tgt; n_halt = 0; n_redir = 0;
        end else if (br) begin
            n_tgt = tgt; n_redir = 1;
        end else if (sf) begin
            n_pc = m_pc;
        end else if (imemReady && m_redir) begin
            n_pc = m_tgt; n_redir = 0;
        end else if (ok) begin
            n_pc = m_pc + 16'd1;
            if (word[15:12] == 4'hF) n_halt = 1;
        end
        if (r || fl) n_dv = 0;
        else if (sd) n_dv = m_dv;
        else if (ok) begin
            n_dv = 1;
            e.instr = word;
            e.pc1   = m_pc + 16'd1;
            exp_q.push_back(e);
        end

        @(posedge clk);
        m_pc = n_pc; m_tgt = n_tgt; m_halt = n_halt; m_redir = n_redir; m_dv = n_dv;
        if (imemReady) outst = 0;
        else if (outst) wcnt++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 16'h0);
    endtask

    // Monitor: state compared every cycle, each newly loaded D entry popped from the scoreboard.
    initial begin : monitor
        bit s_rst, s_sd;
        d_entry_t e;
        forever begin
            @(posedge clk);
            s_rst = rst;
            s_sd  = stallD;
            #1;
            if (!mon_en) continue;
            check("imemAddress", {16'h0, imemAddress}, {16'h0, m_pc});
            check("imemRequest", {31'h0, imemRequest}, {31'h0, !m_halt});
            check("haltedF", {31'h0, haltedF}, {31'h0, m_halt});
            check("validD", {31'h0, validD}, {31'h0, m_dv});
            if (validD === 1'b1 && !s_sd && !s_rst) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL d_entry: got %h/%h, expected none (queue empty)",
                             instructionD, pcPlus1D);
                end else begin
                    e = exp_q.pop_front();
                    check("instructionD", {16'h0, instructionD}, {16'h0, e.instr});
                    check("pcPlus1D", {16'h0, pcPlus1D}, {16'h0, e.pc1});
                end
            end
        end
    end

    initial begin
        logic [15:0] tgt;
        bit r, sf, sd, fl, br;
        // Reset with zero-wait memory
        cycle(1, 0, 0, 0, 0, 16'h0);
        mon_en = 1;
        check("reset_validD", {31'h0, validD}, 32'h0);
        check("reset_instructionD", {16'h0, instructionD}, 32'h0);
        cycle(1, 0, 0, 0, 0, 16'h0);
        run(3);
        #2;
        check("seq_instr", {16'h0, instructionD}, 32'h1002);
        check("seq_pc1", {16'h0, pcPlus1D}, 32'h3);
        // Stall at PC=5
        run(2);
        cycle(0, 1, 1, 0, 0, 16'h0);
        cycle(0, 1, 1, 0, 0, 16'h0);
        #2;
        check("stall_addr", {16'h0, imemAddress}, 32'h5);
        check("stall_hold", {16'h0, instructionD}, 32'h1004);
        run(1);
        #2;
        check("stall_resume", {16'h0, instructionD}, 32'h1005);
        run(2);
        // Branch with ready memory
        cycle(0, 0, 0, 1, 1, 16'h0040);
        #2;
        check("br_addr", {16'h0, imemAddress}, 32'h40);
        check("br_flush", {31'h0, validD}, 32'h0);
        run(1);
        #2;
        check("br_target_instr", {16'h0, instructionD}, 32'h1040);
        // Branch while memory waits 3 cycles at PC=7
        cycle(0, 0, 0, 1, 1, 16'h0007);
        lat_mode = 3;
        cycle(0, 0, 0, 1, 1, 16'h0040);
        run(2);
        #2;
        check("redir_hold_addr", {16'h0, imemAddress}, 32'h7);
        lat_mode = 0;
        run(1);
        #2;
        check("redir_addr", {16'h0, imemAddress}, 32'h40);
        check("redir_discard", {31'h0, validD}, 32'h0);
        run(2);
        // Halt at PC=9
        halt_addr = 9;
        cycle(0, 0, 0, 1, 1, 16'h0009);
        run(1);
        #2;
        check("halt_in_d", {16'h0, instructionD}, 32'hF123);
        check("halt_valid", {31'h0, validD}, 32'h1);
        check("halted", {31'h0, haltedF}, 32'h1);
        run(2);
        #2;
        check("halt_no_req", {31'h0, imemRequest}, 32'h0);
        cycle(0, 0, 0, 1, 1, 16'h0002);
        #2;
        check("unhalt_addr", {16'h0, imemAddress}, 32'h2);
        check("unhalt_flag", {31'h0, haltedF}, 32'h0);
        halt_addr = -1;
        run(1);
        // PC wrap
        cycle(0, 0, 0, 1, 1, 16'hFFFF);
        run(1);
        #2;
        check("wrap_pc1", {16'h0, pcPlus1D}, 32'h0);
        check("wrap_addr", {16'h0, imemAddress}, 32'h0);
        run(2);
        // Randomised traffic
        lat_mode  = -1;
        rand_halt = 1;
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            sf = ($urandom_range(0, 99) < 15);
            sd = ($urandom_range(0, 1) == 0) ? sf : ($urandom_range(0, 99) < 10);
            fl = ($urandom_range(0, 99) < 10);
            br = ($urandom_range(0, 99) < 8);
            tgt = ($urandom_range(0, 19) == 0) ? 16'hFFFE : 16'($urandom_range(0, 255));
            cycle(r, sf, sd, fl, br, tgt);
        end
        run(6);
        #2;
        check("scoreboard_drained", exp_q.size(), 32'h0);
        mon_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 16-bit pipelined core; directly upstream of the hazard unit and decode.
- Owns the PC and drives a variable-latency instruction-memory request/ready interface.
- Applies stallF, stallD, flushD, takeBranchE and branchTargetE.
- Delivers instructionD, pcPlus1D and validD to decode.

Parameters:
WIDTH, 16, instruction width in bits
PCWIDTH, 16, PC width in bits; word addressed, increment is 1
RESET_PC, 16'h0000, PC value loaded on reset
HALT_OPCODE, 4'hF, value of instruction[WIDTH-1:WIDTH-4] that halts fetch

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
stallF  in  1  hold PC (from hazard unit)
stallD  in  1  hold IF/ID register
flushD  in  1  clear IF/ID to a bubble
takeBranchE  in  1  branch resolved taken in E
branchTargetE  in  PCWIDTH  branch target address
imemRequest  out  1  fetch request valid
imemAddress  out  PCWIDTH  fetch address, equals PC
imemReadData  in  WIDTH  instruction word, valid when imemReady=1
imemReady  in  1  memory completes the outstanding request this cycle
instructionD  out  WIDTH  IF/ID instruction
pcPlus1D  out  PCWIDTH  IF/ID PC+1
validD  out  1  IF/ID holds a real instruction
haltedF  out  1  fetch is in HALTED

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset state:
  - PC=RESET_PC, state=FETCH, redirectPending=0, pendingTarget=0.
  - instructionD=NOP (all zeros), pcPlus1D=0, validD=0, haltedF=0.
- FSM states: FETCH and HALTED.
  - imemRequest=1 iff state==FETCH.
  - imemAddress=PC, combinational from the PC register.
- Memory rule: imemAddress must stay stable while imemRequest && !imemReady. The PC never changes mid-request.
- fetchOk = imemReady && !redirectPending && !takeBranchE && !stallF.
- PC/state update each cycle, in priority order:
  1. rst: reset values.
  2. takeBranchE with (imemReady or state==HALTED): PC=branchTargetE, state=FETCH, redirectPending=0.
  3. takeBranchE with a request outstanding and !imemReady: pendingTarget=branchTargetE, redirectPending=1, PC held. A later branch overwrites pendingTarget.
  4. stallF: PC held. Data returned this cycle is dropped and re-fetched.
  5. imemReady && redirectPending: returned data is discarded; PC=pendingTarget; redirectPending=0.
  6. fetchOk: PC=PC+1, wrapping modulo 2^PCWIDTH. If the opcode equals HALT_OPCODE, state=HALTED.
  7. Otherwise: hold.
- HALTED behaviour:
  - PC holds the address after the halt instruction.
  - Leaves HALTED only via takeBranchE or rst. A branch in E is older than the halt, so it wins.
- IF/ID update, in priority order:
  1. rst: NOP, validD=0.
  2. flushD: instructionD=NOP, validD=0, pcPlus1D=0.
  3. stallD: hold all fields.
  4. fetchOk: instructionD=imemReadData, pcPlus1D=PC+1 (wrapped), validD=1.
  5. Otherwise: bubble (NOP, validD=0).
- Latency:
  - Zero-wait memory gives one instruction per cycle; an instruction appears in D the cycle after ready.
  - N wait cycles insert N bubbles.
- Simultaneous events:
  - flushD with stallD: flush wins.
  - takeBranchE with stallF: branch wins.
  - The halt instruction itself enters D with validD=1.
- Reset mid-request: the outstanding request is abandoned. The memory must accept an address change on reset.

Decomposition:
- Package fetch_pkg holds:
  - NOP constant.
  - HALT_OPCODE default.
  - Enum fetch_state_t {FETCH, HALTED}.
- One sub-module, if_id_register: stall/flush/load pipeline register for {instruction, pcPlus1, valid}, parameterised by WIDTH and PCWIDTH.

Test Plan:
- Reset with zero-wait memory returning addr+16'h1000 -> imemAddress 0,1,2 on consecutive cycles; D shows 1000/pc1=1, 1001/pc1=2, 1002/pc1=3; validD=0 during the reset cycle.
- stallF=stallD=1 for 2 cycles at PC=5 -> imemAddress stays 5; D unchanged; fetch resumes at 5 afterwards with no skipped or duplicated valid instruction.
- takeBranchE=1 with target 0x0040 and imemReady=1 -> next imemAddress=0x0040; flushD=1 makes validD=0; next valid D word is from 0x0040.
- takeBranchE at PC=7 while the memory waits 3 cycles -> imemAddress stays 7 until ready; that data is discarded (validD=0); next request is 0x0040.
- Fetch of 16'hF123 at PC=9 -> D gets F123 with validD=1; imemRequest=0 and haltedF=1 from the next cycle; a later takeBranchE to 0x0002 restarts fetch at 2 with haltedF=0.
- PC=0xFFFF fetched with zero wait -> pcPlus1D=0x0000; next imemAddress=0x0000.
